sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
- Multi-cycle N-bit subtractor computing a - b - b_in.
- Processes one DIGIT-bit slice per clock, LSB slice first, and carries the borrow in a register between slices.
- Counterpart to the ripple-carry adder chain: used where a full-width combinational borrow chain would limit clock rate on the DE2 datapath.
- A start/busy/done handshake delivers registered results.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH evenly; otherwise elaboration fails via a generate-time check.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only while idle.
- a  input  WIDTH  minuend, latched when start is accepted.
- b  input  WIDTH  subtrahend, latched when start is accepted.
- b_in  input  1  borrow in, latched when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is complete.
- diff  output  WIDTH  result, held stable until the next accepted start.
- b_out  output  1  final borrow out (unsigned a < b + b_in).
- ovf  output  1  two's-complement signed overflow flag.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE; busy=0, done=0, diff=0, b_out=0, ovf=0. The slice counter and borrow register are also cleared.
- States: IDLE, RUN.
- IDLE -> RUN: start=1 at a rising edge. That edge latches a, b and b_in, sets the borrow register to b_in and the counter to 0, and sets busy=1. It also clears done.
- RUN, each edge: slice k = counter.
  - diff[k*DIGIT +: DIGIT] <= a_l[slice] - b_l[slice] - borrow.
  - borrow <= borrow out of that slice.
  - counter increments.
- Last slice (counter = WIDTH/DIGIT-1): the same edge writes the final slice and sets b_out and ovf. It also sets done=1, sets busy=0 and returns to IDLE.
- Latency: done rises exactly WIDTH/DIGIT edges after the start-accepting edge (4 for the defaults). done falls on the next edge.
- Slice arithmetic:
  - Computed DIGIT+1 bits wide; borrow out = MSB of the extended result.
  - No cross-slice combinational path.
- ovf = (a_l[MSB] != b_l[MSB]) && (diff[MSB] != a_l[MSB]), evaluated on the final result, with b_in included.
- diff during RUN: partially updated and not valid. diff, b_out and ovf are valid from the cycle done=1 until the next accepted start.
- start while busy: ignored, no queuing, latched operands unchanged.
- start while done=1: accepted (state is IDLE). done drops and the next operation begins; back-to-back throughput is one result per WIDTH/DIGIT+... = WIDTH/DIGIT cycles + 1 idle-free restart.
- Operands may change freely after the accepting edge.
- Reset asserted mid-operation: immediate return to reset values. No done pulse is issued for the aborted operation.
- Wrap-around: results are modulo 2^WIDTH; underflow is reported only via b_out.

Optional Feature:
- Macro SUB_SERIAL_SAT_EN.
- Defined: unsigned saturation. On the final edge, if the final borrow = 1, diff is forced to 0 instead of the wrapped value; b_out still reports 1 and ovf is computed on the unsaturated result.
- Undefined: diff is the plain modulo-2^WIDTH result. No extra logic is instantiated.

Test Plan:
- a=0x1234, b=0x0034, b_in=0, start pulse -> busy for 4 cycles, done on 4th edge; diff=0x1200, b_out=0, ovf=0.
- Borrow chain across all slices: a=0x1000, b=0x0001 -> diff=0x0FFF, b_out=0. Then a=0x0010, b=0x000F, b_in=1 -> diff=0x0000, b_out=0.
- Underflow: a=0x0000, b=0x0001 -> diff=0xFFFF, b_out=1, ovf=0. With SUB_SERIAL_SAT_EN: diff=0x0000, b_out=1.
- Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, b_out=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, b_out=1, ovf=1.
- Handshake: start re-pulsed with a=0xFFFF on the 2nd busy cycle -> ignored, result still 0x1200. start asserted in the done cycle with a=0x0005, b=0x0003 -> accepted, diff=0x0002 four edges later.
- Reset: rst_n low on the 2nd RUN cycle, asynchronously mid-cycle -> outputs zero immediately; no done after release. A subsequent start completes correctly.

Source files
------------

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - digit-serial subtractor a - b - b_in, one DIGIT slice per clock, LSB first
// Optional unsigned saturation of diff on final borrow: define SUB_SERIAL_SAT_EN.
module sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int NSL = WIDTH / DIGIT;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({DIGIT{1'b1}});

  generate
    if (WIDTH % DIGIT != 0) begin : g_digit_check
      $error("sub_serial: DIGIT must divide WIDTH evenly");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_b_out;
  logic             r_ovf;

  logic [31:0]      w_shamt;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [DIGIT:0]   w_ext;
  logic             w_brw;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_upd;

  // Slice selection by shifting the latched operands; borrow only crosses slices via r_borrow.
  assign w_shamt    = 32'(r_cnt) * 32'(DIGIT);
  assign w_a_sh     = r_a >> w_shamt;
  assign w_b_sh     = r_b >> w_shamt;
  assign w_ext      = {1'b0, w_a_sh[DIGIT-1:0]} - {1'b0, w_b_sh[DIGIT-1:0]} - (DIGIT+1)'(r_borrow);
  assign w_brw      = w_ext[DIGIT];
  assign w_last     = (r_cnt == CW'(NSL - 1));
  assign w_diff_upd = (r_diff & ~(SLICE_MASK << w_shamt)) | (WIDTH'(w_ext[DIGIT-1:0]) << w_shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_b_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= b_in;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff   <= w_diff_upd;
          r_borrow <= w_brw;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_b_out <= w_brw;
            // Overflow is judged on the unsaturated result.
            r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_upd[WIDTH-1] != r_a[WIDTH-1]);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`ifdef SUB_SERIAL_SAT_EN
            if (w_brw) r_diff <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_b_out;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - directed self-checking bench for sub_serial (WIDTH=16, DIGIT=4)
module tb_sub_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        b_out;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  sub_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then count edges until done (bounded at 20).
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin, output int lat);
    @(negedge clk);
    a = ta; b = tb; b_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    n_checks++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL reset_diff got %h expected 0000", diff); end
    n_checks++; if ({b_out, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b expected 00", {b_out, ovf}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h0034; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b expected 1", busy); end
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d expected 4", lat); end
    n_checks++; if (diff !== 16'h1200) begin n_fail++; $display("FAIL basic_diff got %h expected 1200", diff); end
    n_checks++; if ({b_out, ovf} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b expected 00", {b_out, ovf}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done got %b expected 0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b expected 0", done); end
    n_checks++; if (diff !== 16'h1200) begin n_fail++; $display("FAIL basic_diff_hold got %h expected 1200", diff); end
  endtask

  task automatic test_borrow_chain();
    int lat;
    do_op(16'h1000, 16'h0001, 1'b0, lat);
    n_checks++; if (diff !== 16'h0FFF || lat !== 4) begin n_fail++; $display("FAIL chain1_diff got %h lat %0d expected 0fff lat 4", diff, lat); end
    n_checks++; if ({b_out, ovf} !== 2'b00) begin n_fail++; $display("FAIL chain1_flags got %b expected 00", {b_out, ovf}); end
    do_op(16'h0010, 16'h000F, 1'b1, lat);
    n_checks++; if (diff !== 16'h0000 || lat !== 4) begin n_fail++; $display("FAIL chain2_diff got %h lat %0d expected 0000 lat 4", diff, lat); end
    n_checks++; if ({b_out, ovf} !== 2'b00) begin n_fail++; $display("FAIL chain2_flags got %b expected 00", {b_out, ovf}); end
  endtask

  task automatic test_underflow();
    int lat;
    logic [15:0] exp_d;
`ifdef SUB_SERIAL_SAT_EN
    exp_d = 16'h0000;
`else
    exp_d = 16'hFFFF;
`endif
    do_op(16'h0000, 16'h0001, 1'b0, lat);
    n_checks++; if (diff !== exp_d || lat !== 4) begin n_fail++; $display("FAIL underflow_diff got %h lat %0d expected %h lat 4", diff, lat, exp_d); end
    n_checks++; if ({b_out, ovf} !== 2'b10) begin n_fail++; $display("FAIL underflow_flags got %b expected 10", {b_out, ovf}); end
  endtask

  task automatic test_ovf();
    int lat;
    logic [15:0] exp_d;
    do_op(16'h8000, 16'h0001, 1'b0, lat);
    n_checks++; if (diff !== 16'h7FFF) begin n_fail++; $display("FAIL ovf1_diff got %h expected 7fff", diff); end
    n_checks++; if ({b_out, ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf1_flags got %b expected 01", {b_out, ovf}); end
`ifdef SUB_SERIAL_SAT_EN
    exp_d = 16'h0000;
`else
    exp_d = 16'h8000;
`endif
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
    n_checks++; if (diff !== exp_d) begin n_fail++; $display("FAIL ovf2_diff got %h expected %h", diff, exp_d); end
    n_checks++; if ({b_out, ovf} !== 2'b11) begin n_fail++; $display("FAIL ovf2_flags got %b expected 11", {b_out, ovf}); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h0034; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ignore_latency got %0d expected 4", lat); end
    n_checks++; if (diff !== 16'h1200) begin n_fail++; $display("FAIL ignore_diff got %h expected 1200", diff); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(16'h1234, 16'h0034, 1'b0, lat);
    n_checks++; if (done !== 1'b1 || diff !== 16'h1200) begin n_fail++; $display("FAIL b2b_first got done %b diff %h expected 1 1200", done, diff); end
    a = 16'h0005; b = 16'h0003; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_accept got done,busy %b expected 01", {done, busy}); end
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency got %0d expected 4", lat); end
    n_checks++; if (diff !== 16'h0002) begin n_fail++; $display("FAIL b2b_diff got %h expected 0002", diff); end
  endtask

  task automatic test_async_reset();
    int lat;
    int seen_done;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h1111; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL areset_ctrl got busy,done %b expected 00", {busy, done}); end
    n_checks++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL areset_diff got %h expected 0000", diff); end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (8) begin @(posedge clk); #1; if (done) seen_done++; end
    n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL areset_no_done got %0d pulses expected 0", seen_done); end
    do_op(16'h5555, 16'h1111, 1'b0, lat);
    n_checks++; if (diff !== 16'h4444 || lat !== 4) begin n_fail++; $display("FAIL areset_after got %h lat %0d expected 4444 lat 4", diff, lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_chain();
    test_underflow();
    test_ovf();
    test_busy_ignore();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
